seq_alu: RTL and testbench

Parametrised, multi-cycle ALU with a registered status-flag file (Z, N, C, V) and a start/done handshake. It is the next-generation execute unit for the processor datapath: it adds carry-chained arithmetic (ADC/SBC), arithmetic shifts, and iterative multi-bit shifts, plus an optional iterative multiplier. The control FSM issues one operation at a time and stalls on `Busy`.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/seq_alu_addsub.sv | 30 +++
 rtl/seq_alu.sv | 220 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the sequential ALU: function codes, flag-bit
//               positions within the {Z, N, C, V} flag file, and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // 4-bit function select presented on the Fn port; codes 14..15 are undefined
  typedef enum logic [3:0] {
    FnNOP   = 4'd0,
    FnPASSB = 4'd1,
    FnADD   = 4'd2,
    FnADC   = 4'd3,
    FnSUB   = 4'd4,
    FnSBC   = 4'd5,
    FnAND   = 4'd6,
    FnOR    = 4'd7,
    FnXOR   = 4'd8,
    FnNOT   = 4'd9,
    FnLSL   = 4'd10,
    FnLSR   = 4'd11,
    FnASR   = 4'd12,
    FnMUL   = 4'd13
  } alu_fn_t;

  // Bit positions inside Flags = {Z, N, C, V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Control FSM states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } alu_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/seq_alu_addsub.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_addsub
// Description : Combinational WIDTH-bit adder/subtractor with carry-in.
//               Subtraction is a + ~b + cin, so carry = 1 means no borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;

  // Invert B for subtraction, add with carry-in, derive signed overflow
  always_comb begin
    b_eff           = sub ? ~b : b;
    {carry, sum}    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    overflow        = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule : seq_alu_addsub
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Multi-cycle ALU with registered {Z,N,C,V} flag file and a
//               Start/Done handshake. Shifts iterate one bit per cycle.
//               Define SEQ_ALU_MUL_EN to build the iterative shift-add
//               multiplier for FnMUL; otherwise FnMUL behaves as a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  input  alu_fn_t          Fn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flags,
  output logic             Busy,
  output logic             Done
);

  localparam int SHW = $clog2(WIDTH);
  // Counter holds up to WIDTH multiplier steps, so it needs one extra bit
  localparam int CW  = SHW + 1;

  alu_state_t       state;
  alu_fn_t          run_fn;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;

  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] as_a;
  logic [WIDTH-1:0] as_b;
  logic             as_sub;
  logic             as_cin;
  logic [WIDTH-1:0] as_sum;
  logic             as_carry;
  logic             as_ovf;

  logic [WIDTH-1:0] imm_res;
  logic [3:0]       imm_flags;
  logic             go_run;
  logic             zn;

  logic [WIDTH-1:0] run_res;
  logic             run_c;

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] acc;
  logic             acc_c;
`endif

  assign amt = B[SHW-1:0];

  seq_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (as_a),
    .b        (as_b),
    .sub      (as_sub),
    .cin      (as_cin),
    .sum      (as_sum),
    .carry    (as_carry),
    .overflow (as_ovf)
  );

  // Adder operand select: single-cycle arithmetic in IDLE, accumulate in a MUL run
  always_comb begin
    as_a   = A;
    as_b   = B;
    as_sub = 1'b0;
    as_cin = 1'b0;
    case (Fn)
      FnADC:   as_cin = Flags[FLAG_C];
      FnSUB:   begin as_sub = 1'b1; as_cin = 1'b1;           end
      FnSBC:   begin as_sub = 1'b1; as_cin = Flags[FLAG_C];  end
      default: ;
    endcase
`ifdef SEQ_ALU_MUL_EN
    if (state == ST_RUN) begin
      as_a   = hi;
      as_b   = mcand;
      as_sub = 1'b0;
      as_cin = 1'b0;
    end
`endif
  end

  // Result and flags for operations that complete in the Start cycle
  always_comb begin
    imm_res   = Result;
    imm_flags = Flags;
    go_run    = 1'b0;
    zn        = 1'b0;
    case (Fn)
      FnPASSB: begin imm_res = B;      zn = 1'b1; end
      FnADD, FnADC, FnSUB, FnSBC: begin
        imm_res           = as_sum;
        zn                = 1'b1;
        imm_flags[FLAG_C] = as_carry;
        imm_flags[FLAG_V] = as_ovf;
      end
      FnAND:   begin imm_res = A & B;  zn = 1'b1; end
      FnOR:    begin imm_res = A | B;  zn = 1'b1; end
      FnXOR:   begin imm_res = A ^ B;  zn = 1'b1; end
      FnNOT:   begin imm_res = ~A;     zn = 1'b1; end
      FnLSL, FnLSR, FnASR: begin
        // A zero shift amount finishes immediately with C untouched
        if (amt == '0) begin
          imm_res = A;
          zn      = 1'b1;
        end else begin
          go_run  = 1'b1;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      FnMUL:   go_run = 1'b1;
`endif
      default: ;
    endcase
    if (zn) begin
      imm_flags[FLAG_Z] = (imm_res == '0);
      imm_flags[FLAG_N] = imm_res[WIDTH-1];
    end
  end

  // One iteration step of the running operation (shift bit or multiplier bit)
  always_comb begin
    case (run_fn)
      FnLSL:   begin run_res = {work[WIDTH-2:0], 1'b0};         run_c = work[WIDTH-1]; end
      FnLSR:   begin run_res = {1'b0, work[WIDTH-1:1]};         run_c = work[0];       end
      default: begin run_res = {work[WIDTH-1], work[WIDTH-1:1]}; run_c = work[0];      end
    endcase
`ifdef SEQ_ALU_MUL_EN
    // {hi, work} holds the partial product with the multiplier in the low half
    if (work[0]) begin
      acc   = as_sum;
      acc_c = as_carry;
    end else begin
      acc   = hi;
      acc_c = 1'b0;
    end
    hi_next = {acc_c, acc[WIDTH-1:1]};
    if (run_fn == FnMUL) begin
      run_res = {acc[0], work[WIDTH-1:1]};
      run_c   = (hi_next != '0);
    end
`endif
  end

  // Control FSM with registered Result/Flags/Busy/Done
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state  <= ST_IDLE;
      run_fn <= FnNOP;
      work   <= '0;
      cnt    <= '0;
      Result <= '0;
      Flags  <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      hi     <= '0;
      mcand  <= '0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            if (go_run) begin
              state  <= ST_RUN;
              Busy   <= 1'b1;
              run_fn <= Fn;
              work   <= A;
              cnt    <= CW'(amt);
`ifdef SEQ_ALU_MUL_EN
              hi     <= '0;
              mcand  <= A;
              if (Fn == FnMUL) begin
                work <= B;
                cnt  <= CW'(WIDTH);
              end
`endif
            end else begin
              Result <= imm_res;
              Flags  <= imm_flags;
              Done   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          cnt  <= cnt - CW'(1);
          work <= run_res;
`ifdef SEQ_ALU_MUL_EN
          hi   <= hi_next;
`endif
          if (cnt == CW'(1)) begin
            state         <= ST_IDLE;
            Busy          <= 1'b0;
            Done          <= 1'b1;
            Result        <= run_res;
            Flags[FLAG_Z] <= (run_res == '0);
            Flags[FLAG_N] <= run_res[WIDTH-1];
            Flags[FLAG_C] <= run_c;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : seq_alu
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Scoreboard bench for seq_alu (WIDTH=16). Stimulus pushes the
//               hand-computed result, flags and Done cycle; a monitor pops on
//               every Done. Honours SEQ_ALU_MUL_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  alu_fn_t      fn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         busy;
  logic         done;

  exp_t q[$];
  exp_t e;
  int   cyc;
  int   n_vec;
  int   n_cmp;
  int   errs;

  seq_alu #(.WIDTH(W)) dut (
    .Clock  (clk),
    .nReset (rst_n),
    .Start  (start),
    .Fn     (fn),
    .A      (a),
    .B      (b),
    .Result (result),
    .Flags  (flags),
    .Busy   (busy),
    .Done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) begin
        errs++;
        $display("FAIL busy_done_overlap: Busy and Done both high at cycle %0d", cyc);
      end
      if (done) begin
        if (q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_done: result %h flags %b at cycle %0d, none expected", result, flags, cyc);
        end else begin
          e = q.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("flags",  32'(flags),  32'(e.flg));
          check("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Drive one op at the current negedge; lat = RUN cycles before Done
  task automatic issue(input alu_fn_t f, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] er, input logic [3:0] ef, input int lat);
    exp_t x;
    fn    = f;
    a     = va;
    b     = vb;
    start = 1'b1;
    x.res = er;
    x.flg = ef;
    x.cyc = cyc + 1 + lat;
    q.push_back(x);
    n_vec++;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < lat; i++) begin
      check("busy_high", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    cyc   = 0;
    n_vec = 0;
    n_cmp = 0;
    errs  = 0;
    rst_n = 1'b0;
    start = 1'b0;
    fn    = FnNOP;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_result", 32'(result), 32'd0);
    check("reset_flags",  32'(flags),  32'd0);
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Arithmetic, carries and overflow
    issue(FnADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 0);
    issue(FnADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 0);
    issue(FnADC, 16'h0001, 16'h0001, 16'h0003, 4'b0000, 0);
    // Iterative shifts
    issue(FnLSL, 16'h8001, 16'd3,    16'h0008, 4'b0000, 3);
    issue(FnASR, 16'h8000, 16'd15,   16'hFFFF, 4'b0100, 15);
    issue(FnSUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 0);
    // Zero shift: single cycle, C and V untouched
    issue(FnLSR, 16'h00F0, 16'd0,    16'h00F0, 4'b0011, 0);
    issue(FnSUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100, 0);
    issue(FnSBC, 16'h0005, 16'h0003, 16'h0001, 4'b0010, 0);
    // Back-to-back logic ops with Start held high
    issue(FnAND,   16'hF0F0, 16'hFF00, 16'hF000, 4'b0110, 0);
    issue(FnOR,    16'h0000, 16'h0000, 16'h0000, 4'b1010, 0);
    issue(FnXOR,   16'hAAAA, 16'h5555, 16'hFFFF, 4'b0110, 0);
    issue(FnNOT,   16'hFFFF, 16'h0000, 16'h0000, 4'b1010, 0);
    issue(FnPASSB, 16'h0000, 16'h1234, 16'h1234, 4'b0010, 0);
    issue(FnNOP,   16'hFFFF, 16'hFFFF, 16'h1234, 4'b0010, 0);
    issue(alu_fn_t'(4'hE), 16'h0001, 16'h0001, 16'h1234, 4'b0010, 0);
`ifdef SEQ_ALU_MUL_EN
    issue(FnMUL, 16'h00FF, 16'h0101, 16'hFFFF, 4'b0100, W);
    issue(FnMUL, 16'h0100, 16'h0100, 16'h0000, 4'b1010, W);
`else
    issue(FnMUL, 16'h00FF, 16'h0101, 16'h1234, 4'b0010, 0);
`endif
    @(negedge clk);

    // Start pulsed mid-RUN must be ignored: one Done only
    fn = FnLSR; a = 16'h8000; b = 16'd4; start = 1'b1;
    begin
      exp_t x;
      x.res = 16'h0800; x.flg = 4'b0000; x.cyc = cyc + 1 + 4;
      q.push_back(x);
      n_vec++;
    end
    @(negedge clk); start = 1'b0;
    @(negedge clk); fn = FnADD; a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);

    issue(FnPASSB, 16'h0000, 16'hFFFF, 16'hFFFF, 4'b0100, 0);

    // Asynchronous reset in the middle of a 10-step shift
    fn = FnLSL; a = 16'h0001; b = 16'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags",  32'(flags),  32'd0);
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_done",   32'(done),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(FnADD, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 0);

    // Drain: all expectations must have been consumed
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    while (q.size() != 0) begin
      e = q.pop_front();
      errs++;
      $display("FAIL missing_done: expected result %h flags %b at cycle %0d never seen", e.res, e.flg, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
    $finish;
  end

endmodule : tb_seq_alu
`default_nettype wire
